// File: rtl/vec_cmd_sched.sv
// Shares one VecUnit datapath between N_REQ requesters: arbitrate, read, execute, write back.
// Define VEC_CMD_SCHED_RR_EN for round-robin arbitration; otherwise lowest index wins.
module vec_cmd_sched #(
    parameter int N_REQ    = 2,
    parameter int REG_AW   = 4,
    parameter int EXEC_LAT = 1,
    localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [2*N_REQ-1:0]      req_op,
    input  logic [REG_AW*N_REQ-1:0] req_src1,
    input  logic [REG_AW*N_REQ-1:0] req_src2,
    input  logic [REG_AW*N_REQ-1:0] req_dst,
    output logic [1:0]              vu_op,
    output logic [REG_AW-1:0]       rf_rd_addr1,
    output logic [REG_AW-1:0]       rf_rd_addr2,
    output logic                    rf_wr_en,
    output logic [REG_AW-1:0]       rf_wr_addr,
    output logic                    done_valid,
    output logic [ID_W-1:0]         done_id,
    output logic                    busy
);
    localparam int CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    typedef struct packed {
        logic [1:0]        op;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic [REG_AW-1:0] dst;
    } cmd_t;

    logic [N_REQ-1:0][1:0]        op_arr;
    logic [N_REQ-1:0][REG_AW-1:0] src1_arr, src2_arr, dst_arr;

    assign op_arr   = req_op;
    assign src1_arr = req_src1;
    assign src2_arr = req_src2;
    assign dst_arr  = req_dst;

    state_t          state, state_nx;
    cmd_t            cmd;
    logic [ID_W-1:0] owner;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0] win;
    logic            any_valid, accept;

    assign any_valid = |req_valid;
    assign accept    = (state == IDLE) && any_valid;

`ifdef VEC_CMD_SCHED_RR_EN
    logic [ID_W-1:0] rr_ptr;
    int              k;

    // Scan downward so the requester closest to rr_ptr overwrites the others.
    always_comb begin
        win = '0;
        k   = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = (int'(rr_ptr) + i) % N_REQ;
            if (req_valid[ID_W'(k)]) win = ID_W'(k);
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
    end
`else
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req_valid[i]) win = ID_W'(i);
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req_ready  = '0;
        rf_wr_en   = 1'b0;
        done_valid = 1'b0;
        case (state)
            IDLE: if (any_valid) begin
                req_ready[win] = 1'b1;
                state_nx       = READ;
            end
            READ:  state_nx = EXEC;
            EXEC:  if (cnt == '0) state_nx = WRITE;
            WRITE: begin
                rf_wr_en   = 1'b1;
                done_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latched command stays on the datapath ports until the next accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd   <= '0;
            owner <= '0;
            cnt   <= '0;
        end else begin
            if (accept) begin
                cmd.op   <= op_arr[win];
                cmd.src1 <= src1_arr[win];
                cmd.src2 <= src2_arr[win];
                cmd.dst  <= dst_arr[win];
                owner    <= win;
            end
            if (state == READ)
                cnt <= CNT_W'(EXEC_LAT - 1);
            else if (state == EXEC && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    assign vu_op       = cmd.op;
    assign rf_rd_addr1 = cmd.src1;
    assign rf_rd_addr2 = cmd.src2;
    assign rf_wr_addr  = cmd.dst;
    assign done_id     = owner;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_vec_cmd_sched.sv
// Scoreboard bench for vec_cmd_sched: three instances (EXEC_LAT 1, 3, 2) driven by directed vectors.
module tb_vec_cmd_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rb;

    logic [1:0] a_valid, a_ready, a_op_o;
    logic [3:0] a_op;
    logic [7:0] a_s1, a_s2, a_dst;
    logic [3:0] a_rd1, a_rd2, a_wa;
    logic       a_wen, a_done, a_busy;
    logic [0:0] a_id;

    logic [1:0] b_valid, b_ready, b_op_o;
    logic [3:0] b_op;
    logic [7:0] b_s1, b_s2, b_dst;
    logic [3:0] b_rd1, b_rd2, b_wa;
    logic       b_wen, b_done, b_busy;
    logic [0:0] b_id;

    logic [1:0] c_valid, c_ready, c_op_o;
    logic [3:0] c_op;
    logic [7:0] c_s1, c_s2, c_dst;
    logic [3:0] c_rd1, c_rd2, c_wa;
    logic       c_wen, c_done, c_busy;
    logic [0:0] c_id;

    vec_cmd_sched #(.N_REQ(2), .REG_AW(4), .EXEC_LAT(1)) u_a (
        .clock(clk), .reset(rst), .req_valid(a_valid), .req_ready(a_ready),
        .req_op(a_op), .req_src1(a_s1), .req_src2(a_s2), .req_dst(a_dst),
        .vu_op(a_op_o), .rf_rd_addr1(a_rd1), .rf_rd_addr2(a_rd2), .rf_wr_en(a_wen),
        .rf_wr_addr(a_wa), .done_valid(a_done), .done_id(a_id), .busy(a_busy));

    vec_cmd_sched #(.N_REQ(2), .REG_AW(4), .EXEC_LAT(3)) u_b (
        .clock(clk), .reset(rst | rb), .req_valid(b_valid), .req_ready(b_ready),
        .req_op(b_op), .req_src1(b_s1), .req_src2(b_s2), .req_dst(b_dst),
        .vu_op(b_op_o), .rf_rd_addr1(b_rd1), .rf_rd_addr2(b_rd2), .rf_wr_en(b_wen),
        .rf_wr_addr(b_wa), .done_valid(b_done), .done_id(b_id), .busy(b_busy));

    vec_cmd_sched #(.N_REQ(2), .REG_AW(4), .EXEC_LAT(2)) u_c (
        .clock(clk), .reset(rst), .req_valid(c_valid), .req_ready(c_ready),
        .req_op(c_op), .req_src1(c_s1), .req_src2(c_s2), .req_dst(c_dst),
        .vu_op(c_op_o), .rf_rd_addr1(c_rd1), .rf_rd_addr2(c_rd2), .rf_wr_en(c_wen),
        .rf_wr_addr(c_wa), .done_valid(c_done), .done_id(c_id), .busy(c_busy));

    typedef struct {
        int inst;
        int id;
        int addr;
        int op;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

`ifdef VEC_CMD_SCHED_RR_EN
    int g_seq[4] = '{0, 1, 0, 1};
`else
    int g_seq[4] = '{0, 0, 0, 0};
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int inst, input int id, input int addr, input int op);
        exp_t e;
        e.inst = inst; e.id = id; e.addr = addr; e.op = op;
        sb.push_back(e);
    endtask

    task automatic check_done(input int inst, input int id, input int addr, input int op, input int wen);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL done_unexpected: inst %0d id=%0d addr=%0d, no completion expected", inst, id, addr);
        end else begin
            e = sb.pop_front();
            chk("done_inst", inst, e.inst);
            chk("done_id", id, e.id);
            chk("done_wr_addr", addr, e.addr);
            chk("done_vu_op", op, e.op);
            chk("done_wr_en", wen, 1);
        end
    endtask

    // Monitor: every completion pulse on any instance consumes one scoreboard entry.
    always @(negedge clk) begin
        if (a_done === 1'b1) check_done(0, int'(a_id), int'(a_wa), int'(a_op_o), int'(a_wen));
        if (b_done === 1'b1) check_done(1, int'(b_id), int'(b_wa), int'(b_op_o), int'(b_wen));
        if (c_done === 1'b1) check_done(2, int'(c_id), int'(c_wa), int'(c_op_o), int'(c_wen));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int r, input int op, input int s1, input int s2, input int d);
        a_op[2*r +: 2]  = 2'(op);
        a_s1[4*r +: 4]  = 4'(s1);
        a_s2[4*r +: 4]  = 4'(s2);
        a_dst[4*r +: 4] = 4'(d);
    endtask

    initial begin
        rst = 1'b1; rb = 1'b0;
        a_valid = '0; a_op = '0; a_s1 = '0; a_s2 = '0; a_dst = '0;
        b_valid = '0; b_op = '0; b_s1 = '0; b_s2 = '0; b_dst = '0;
        c_valid = '0; c_op = '0; c_s1 = '0; c_s2 = '0; c_dst = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_ready", a_ready, 0);
        chk("rst_vu_op", a_op_o, 0);
        chk("rst_rd1", a_rd1, 0);
        chk("rst_rd2", a_rd2, 0);
        chk("rst_wr_addr", a_wa, 0);
        chk("rst_wr_en", a_wen, 0);
        chk("rst_done", a_done, 0);
        chk("rst_done_id", a_id, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_busy_b", b_busy, 0);
        chk("rst_busy_c", c_busy, 0);
        tick(); rst = 1'b0;

        // Single ADD from requester 0: src1=2 src2=3 dst=5
        tick();
        set_a(0, 0, 2, 3, 5); a_valid = 2'b01;
        push_exp(0, 0, 5, 0);
        @(negedge clk); chk("single_ready_T", a_ready, 2'b01);
        tick(); a_valid = '0;
        @(negedge clk);
        chk("single_rd1_T1", a_rd1, 2);
        chk("single_rd2_T1", a_rd2, 3);
        chk("single_busy_T1", a_busy, 1);
        chk("single_ready_T1", a_ready, 0);
        tick(); @(negedge clk); chk("single_wr_en_T2", a_wen, 0);
        tick(); @(negedge clk);
        chk("single_wr_en_T3", a_wen, 1);
        chk("single_wr_addr_T3", a_wa, 5);
        chk("single_done_id_T3", a_id, 0);
        tick(); @(negedge clk); chk("single_busy_T4", a_busy, 0);

        // Contention from a fresh reset: both requesters hold valid for four grants
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        set_a(0, 1, 1, 1, 8);
        set_a(1, 2, 2, 3, 9);
        a_valid = 2'b11;
        for (int g = 0; g < 4; g++)
            push_exp(0, g_seq[g], (g_seq[g] != 0) ? 9 : 8, (g_seq[g] != 0) ? 2 : 1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("cont_ready_%0d", k), a_ready,
                (k % 4 == 0) ? (32'd1 << g_seq[k/4]) : 32'd0);
            if (k % 4 == 1)
                chk($sformatf("cont_rd1_%0d", k), a_rd1, (g_seq[k/4] != 0) ? 2 : 1);
            tick();
        end
        a_valid = '0;

        // Backpressure: requester 1 raises valid while requester 0's command is in flight
        set_a(0, 0, 4, 5, 6);
        set_a(1, 1, 10, 11, 12);
        a_valid = 2'b01;
        push_exp(0, 0, 6, 0);
        push_exp(0, 1, 12, 1);
        @(negedge clk); chk("bp_ready_T", a_ready, 2'b01);
        tick(); a_valid = 2'b10;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk); chk($sformatf("bp_hold_%0d", k), a_ready, 0);
            tick();
        end
        @(negedge clk); chk("bp_ready_T4", a_ready, 2'b10);
        tick(); a_valid = '0;
        @(negedge clk); chk("bp_rd1_T5", a_rd1, 10);
        repeat (4) tick();

        // Reset during EXEC on the EXEC_LAT=3 instance
        b_op = 4'b0100; b_s1 = 8'h21; b_s2 = 8'h32; b_dst = 8'he0 | 8'h0d;
        b_valid = 2'b01;
        @(negedge clk); chk("rmid_ready_T", b_ready, 2'b01);
        tick(); b_valid = '0;
        tick();
        tick(); rb = 1'b1;
        @(negedge clk); chk("rmid_busy_T3", b_busy, 1);
        tick(); rb = 1'b0;
        @(negedge clk);
        chk("rmid_busy_T4", b_busy, 0);
        chk("rmid_wr_en_T4", b_wen, 0);
        chk("rmid_done_T4", b_done, 0);
        chk("rmid_vu_op_T4", b_op_o, 0);
        for (int k = 5; k < 8; k++) begin
            tick(); @(negedge clk);
            chk($sformatf("rmid_wr_en_T%0d", k), b_wen, 0);
            chk($sformatf("rmid_done_T%0d", k), b_done, 0);
        end
        tick();
        b_valid = 2'b11;
        push_exp(1, 0, 13, 0);
        @(negedge clk); chk("rmid_ptr_ready", b_ready, 2'b01);
        tick(); b_valid = '0;
        repeat (5) tick();

        // SCALE with dst == src1 == 7 on the EXEC_LAT=2 instance
        c_op = 4'b0011; c_s1 = 8'h07; c_s2 = 8'h00; c_dst = 8'h07;
        c_valid = 2'b01;
        push_exp(2, 0, 7, 3);
        @(negedge clk); chk("scale_ready_T", c_ready, 2'b01);
        tick(); c_valid = '0;
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                chk($sformatf("scale_vu_op_T%0d", k), c_op_o, 3);
                chk($sformatf("scale_rd1_T%0d", k), c_rd1, 7);
            end
            chk($sformatf("scale_wr_en_T%0d", k), c_wen, (k == 4) ? 1 : 0);
            if (k == 4) chk("scale_wr_addr_T4", c_wa, 7);
            if (k == 5) chk("scale_busy_T5", c_busy, 0);
            tick();
        end

        repeat (2) tick();
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end
endmodule

// File: doc/vec_cmd_sched.md
# vec_cmd_sched

Command scheduler that shares one `VecUnit` datapath between `N_REQ` requesters. It arbitrates incoming vector commands (ADD/SUB/DOT/SCALE with register operands), sequences each accepted command through vector register-file read, execute and write-back, and reports completion to the owning requester. It sits between the core's vector issue ports and the `VecUnit` plus vector register file. One command is in flight at a time.

## Interface

Parameters:
- `N_REQ`, 2: number of requesters (≥1).
- `REG_AW`, 4: vector register address width.
- `EXEC_LAT`, 1: cycles the datapath result needs to settle before write-back (≥1).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  N_REQ  per-requester command valid.
- `req_ready`  out  N_REQ  per-requester accept; one-hot or zero.
- `req_op`  in  2*N_REQ  op per requester, `VecOp_t` encoding (0 ADD, 1 SUB, 2 DOT, 3 SCALE); requester i at bits [2i+1:2i].
- `req_src1`, `req_src2`, `req_dst`  in  REG_AW*N_REQ  register addresses per requester, packed the same way.
- `vu_op`  out  2  op driven to `VecUnit`.
- `rf_rd_addr1`, `rf_rd_addr2`  out  REG_AW  register-file read addresses (1-cycle read latency).
- `rf_wr_en`  out  1  write-back strobe.
- `rf_wr_addr`  out  REG_AW  write-back address.
- `done_valid`  out  1  one-cycle completion pulse.
- `done_id`  out  $clog2(N_REQ) (min 1)  requester that owned the completed command.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE: if any `req_valid`, the arbiter picks winner w and asserts `req_ready[w]` combinationally. On that cycle's edge, latch op/src1/src2/dst/w and go to READ. If no `req_valid`, stay in IDLE and keep `req_ready` = 0.
- `req_ready` is 0 in every state except IDLE. A requester may drop `req_valid` without penalty. Command fields only need to be stable while valid && ready.
- READ: drive `rf_rd_addr1`/`rf_rd_addr2` from the latched sources, then go to EXEC.
- EXEC: a down-counter loaded with EXEC_LAT-1 counts to 0, then the FSM goes to WRITE.
- WRITE: `rf_wr_en`=1, `rf_wr_addr`=dst, `done_valid`=1, `done_id`=w. Then go to IDLE.
- `vu_op` and the read addresses hold the latched values from READ through WRITE. In IDLE they hold their last values.
- The arbiter updates its state only on an accepted handshake.
- dst equal to src1/src2 is legal. The read completes before the write, so no hazard exists.
- SCALE uses only src1. src2 is still driven, and its value is don't-care.
- Reset at any cycle returns the FSM to IDLE and aborts any in-flight command. No write-back and no `done_valid` occur for the aborted command.

## Timing

- Reset values: `req_ready`=0, `vu_op`=0, all addresses 0, `rf_wr_en`=0, `done_valid`=0, `done_id`=0, `busy`=0, round-robin pointer=0.
- Handshake at cycle T:
  - READ at T+1.
  - EXEC at T+2 … T+1+EXEC_LAT.
  - WRITE at T+2+EXEC_LAT.
  - Next accept possible at T+3+EXEC_LAT.
- With EXEC_LAT=1, one command completes every 4 cycles under saturation.
- `rf_wr_en` and `done_valid` are single-cycle and coincident.

## Configuration

- `VEC_CMD_SCHED_RR_EN` defined: round-robin arbitration. A pointer p names the highest-priority requester. Search runs p, p+1, … mod N_REQ. After granting w, p ← (w+1) mod N_REQ.
- `VEC_CMD_SCHED_RR_EN` undefined: fixed priority, lowest index wins. No pointer register exists. Starvation of higher indices is permitted.

## Test plan

- Single command, EXEC_LAT=1: req 0 sends ADD src1=2 src2=3 dst=5 at T. Required: `rf_rd_addr1`=2 and `rf_rd_addr2`=3 at T+1; `rf_wr_en`=1, `rf_wr_addr`=5, `done_id`=0 at T+3; `busy`=0 at T+4.
- Contention, RR_EN defined, N_REQ=2: both requesters hold `req_valid` continuously. Required: grants alternate 0,1,0,1 at T, T+4, T+8, T+12.
- Contention, RR_EN undefined: same stimulus. Required: every grant goes to requester 0 and `req_ready[1]` never rises.
- Backpressure: req 1 asserts valid during READ/EXEC of a req-0 command. Required: `req_ready[1]`=0 until IDLE, and req 1's command is accepted on the first IDLE cycle.
- Reset mid-op: assert `reset` during EXEC with EXEC_LAT=3. Required: `rf_wr_en` and `done_valid` stay 0, `busy`=0 the cycle after, and the next command behaves as if after power-on (RR pointer=0).
- SCALE with dst=src1=7, EXEC_LAT=2. Required: `vu_op`=3 held from READ through WRITE, and the write to 7 occurs at T+4.
